// File: rtl/bitwise_result_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_pkg
//  Description : Shared opcode encodings, checker FSM states and the stimulus
//                opcode rotation used by the bitwise result checker and its
//                benches.
//  Revision    : 1.0 - initial release
// ============================================================================
package bitwise_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Stimulus opcode rotation: AND -> OR -> NOT -> XOR -> AND
  function automatic logic [1:0] next_op(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      OP_AND:  nxt = OP_OR;
      OP_OR:   nxt = OP_NOT;
      OP_NOT:  nxt = OP_XOR;
      default: nxt = OP_AND;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitwise_result_checker_ref_model.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_ref_model
//  Description : Combinational expected-value function of the bitwise unit.
//                Carry-free, all operations W bits wide.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitwise_ref_model
  import bitwise_pkg::*;
#(
  parameter int unsigned W = 7
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  // Select the expected result for the presented opcode
  always_comb begin
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = ~a;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bitwise_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_result_checker
//  Description : Response checker for the bitwise-operations unit. Expected
//                results travel down a LATENCY-deep delay line and are
//                compared against the unit's q; checks, errors and the first
//                failure index are recorded per run.
//  Options     : BITWISE_CHECK_SEQ_EN - also enforce the opcode rotation and
//                expose the sticky seq_err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitwise_result_checker
  import bitwise_pkg::*;
#(
  parameter int unsigned W          = 7,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned NUM_CHECKS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  input  logic [W-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         mismatch,
  output logic [15:0]  chk_count,
  output logic [15:0]  err_count,
  output logic [15:0]  first_err_idx,
  output logic         first_err_valid
`ifdef BITWISE_CHECK_SEQ_EN
  ,
  output logic         seq_err
`endif
);

  localparam int unsigned HEAD   = LATENCY - 1;
  localparam logic [15:0] C_LAST = 16'(NUM_CHECKS);

  logic [W-1:0]       exp_now;
  state_e             state_q, state_d;
  logic [W-1:0]       exp_q [LATENCY];
  logic [W-1:0]       exp_d [LATENCY];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [15:0]        chk_count_q, chk_count_d;
  logic [15:0]        err_count_q, err_count_d;
  logic [15:0]        first_err_idx_q, first_err_idx_d;
  logic               first_err_valid_q, first_err_valid_d;
  logic               mismatch_q, mismatch_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               run_start, data_fail, fail;
`ifdef BITWISE_CHECK_SEQ_EN
  logic [1:0]         op_q [LATENCY];
  logic [1:0]         op_d [LATENCY];
  logic [1:0]         prev_op_q, prev_op_d;
  logic               seq_err_q, seq_err_d;
  logic               seq_fail;
`endif

  bitwise_ref_model #(.W(W)) u_ref_model (
    .a  (a),
    .b  (b),
    .op (op),
    .y  (exp_now)
  );

  // Delay line shift, FSM next state and result bookkeeping
  always_comb begin
    run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Samples are only marked valid while a run is in progress
    exp_d[0] = exp_now;
    vld_d[0] = busy_q;
    for (int i = 1; i < int'(LATENCY); i++) begin
      exp_d[i] = exp_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
    if (run_start) begin
      vld_d = '0;
    end

    // Case inequality so an X/Z result from the unit counts as a failure
    data_fail = (state_q == ST_CHECK) && (q !== exp_q[HEAD]);

`ifdef BITWISE_CHECK_SEQ_EN
    op_d[0] = op;
    for (int i = 1; i < int'(LATENCY); i++) begin
      op_d[i] = op_q[i-1];
    end
    // The first compare of a run has no predecessor to check against
    seq_fail  = (state_q == ST_CHECK) && (chk_count_q != 16'd0) &&
                (op_q[HEAD] != next_op(prev_op_q));
    fail      = data_fail || seq_fail;
    prev_op_d = (state_q == ST_CHECK) ? op_q[HEAD] : prev_op_q;
    seq_err_d = run_start ? 1'b0 : (seq_err_q || seq_fail);
`else
    fail = data_fail;
`endif

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run_start) state_d = ST_FILL;
      ST_FILL:  if (vld_d[HEAD]) state_d = ST_CHECK;
      ST_CHECK: if (chk_count_q + 16'd1 == C_LAST) state_d = ST_DONE;
      ST_DONE:  if (run_start) state_d = ST_FILL;
      default:  state_d = ST_IDLE;
    endcase

    chk_count_d       = chk_count_q;
    err_count_d       = err_count_q;
    first_err_idx_d   = first_err_idx_q;
    first_err_valid_d = first_err_valid_q;
    mismatch_d        = 1'b0;
    if (run_start) begin
      chk_count_d       = 16'd0;
      err_count_d       = 16'd0;
      first_err_idx_d   = 16'd0;
      first_err_valid_d = 1'b0;
    end else if (state_q == ST_CHECK) begin
      chk_count_d = chk_count_q + 16'd1;
      if (fail) begin
        mismatch_d = 1'b1;
        if (err_count_q != 16'hFFFF) begin
          err_count_d = err_count_q + 16'd1;
        end
        if (!first_err_valid_q) begin
          first_err_idx_d   = chk_count_q;
          first_err_valid_d = 1'b1;
        end
      end
    end

    busy_d = (state_d == ST_FILL) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_count_d == 16'd0);
  end

  // State, delay line and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      vld_q             <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        exp_q[i] <= '0;
      end
      chk_count_q       <= 16'd0;
      err_count_q       <= 16'd0;
      first_err_idx_q   <= 16'd0;
      first_err_valid_q <= 1'b0;
      mismatch_q        <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
`ifdef BITWISE_CHECK_SEQ_EN
      for (int i = 0; i < int'(LATENCY); i++) begin
        op_q[i] <= 2'b00;
      end
      prev_op_q         <= 2'b00;
      seq_err_q         <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      vld_q             <= vld_d;
      exp_q             <= exp_d;
      chk_count_q       <= chk_count_d;
      err_count_q       <= err_count_d;
      first_err_idx_q   <= first_err_idx_d;
      first_err_valid_q <= first_err_valid_d;
      mismatch_q        <= mismatch_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
`ifdef BITWISE_CHECK_SEQ_EN
      op_q              <= op_d;
      prev_op_q         <= prev_op_d;
      seq_err_q         <= seq_err_d;
`endif
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign mismatch        = mismatch_q;
  assign chk_count       = chk_count_q;
  assign err_count       = err_count_q;
  assign first_err_idx   = first_err_idx_q;
  assign first_err_valid = first_err_valid_q;
`ifdef BITWISE_CHECK_SEQ_EN
  assign seq_err         = seq_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitwise_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitwise_result_checker
//  Description : Bench for bitwise_result_checker. Two checkers (LATENCY 1
//                and 3) watch behavioural units; a run-level model predicts
//                every output each cycle, plus directed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_result_checker;
  import bitwise_pkg::*;

  localparam int W  = 7;
  localparam int N  = 20;
  localparam int L1 = 1;
  localparam int L3 = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0]   op = 2'b00;
  logic         inj = 1'b0;
  logic         use3 = 1'b0;
  logic [W-1:0] u1_q;
  logic [W-1:0] u3_p [3];
  logic [W-1:0] q1, q3;

  logic         busy1, done1, pass1, mis1, fev1, s1;
  logic [15:0]  chk1, err1, idx1;
  logic         busy3, done3, pass3, mis3, fev3, s3;
  logic [15:0]  chk3, err3, idx3;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] f(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // Behavioural units: 1-stage (with fault injection on bit 0) and 3-stage
  always @(posedge clk) begin
    u1_q    <= f(a, b, op) ^ {{(W-1){1'b0}}, inj};
    u3_p[0] <= f(a, b, op);
    u3_p[1] <= u3_p[0];
    u3_p[2] <= u3_p[1];
  end
  assign q1 = use3 ? u3_p[2] : u1_q;
  assign q3 = u3_p[2];

  bitwise_result_checker #(.W(W), .LATENCY(L1), .NUM_CHECKS(N)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op), .q(q1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch(mis1),
    .chk_count(chk1), .err_count(err1), .first_err_idx(idx1),
    .first_err_valid(fev1)
`ifdef BITWISE_CHECK_SEQ_EN
    , .seq_err(s1)
`endif
  );

  bitwise_result_checker #(.W(W), .LATENCY(L3), .NUM_CHECKS(N)) dut3 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op), .q(q3),
    .busy(busy3), .done(done3), .pass(pass3), .mismatch(mis3),
    .chk_count(chk3), .err_count(err3), .first_err_idx(idx3),
    .first_err_valid(fev3)
`ifdef BITWISE_CHECK_SEQ_EN
    , .seq_err(s3)
`endif
  );

`ifndef BITWISE_CHECK_SEQ_EN
  assign s1 = 1'b0;
  assign s3 = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- run-level model: sample index / compare index ---------
  bit           m_busy [2], m_done [2], m_mis [2], m_fev [2], m_seq [2];
  int           m_chk [2], m_err [2], m_idx [2], m_age [2];
  logic [W-1:0] m_smp [2][128];
  logic [1:0]   m_op  [2][128];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [W-1:0] qd;
      int           lat, k;
      bit           bad;
      qd = (d == 0) ? q1 : q3;
      lat = (d == 0) ? L1 : L3;
      m_mis[d] = 1'b0;
      if (rst) begin
        m_busy[d] = 0; m_done[d] = 0; m_fev[d] = 0; m_seq[d] = 0;
        m_chk[d] = 0; m_err[d] = 0; m_idx[d] = 0; m_age[d] = 0;
      end else if (start && !m_busy[d]) begin
        m_busy[d] = 1; m_done[d] = 0; m_fev[d] = 0; m_seq[d] = 0;
        m_chk[d] = 0; m_err[d] = 0; m_idx[d] = 0; m_age[d] = 0;
      end else if (m_busy[d]) begin
        m_smp[d][m_age[d]] = f(a, b, op);
        m_op[d][m_age[d]]  = op;
        if (m_age[d] >= lat) begin
          k   = m_age[d] - lat;
          bad = (qd !== m_smp[d][k]);
`ifdef BITWISE_CHECK_SEQ_EN
          if (k > 0 && m_op[d][k] != next_op(m_op[d][k-1])) begin
            bad = 1; m_seq[d] = 1;
          end
`endif
          m_chk[d] = k + 1;
          if (bad) begin
            m_mis[d] = 1;
            if (m_err[d] < 65535) m_err[d]++;
            if (!m_fev[d]) begin m_fev[d] = 1; m_idx[d] = k; end
          end
          if (m_chk[d] == N) begin m_busy[d] = 0; m_done[d] = 1; end
        end
        m_age[d]++;
      end
    end
  end

  function automatic logic [63:0] mpack(input int d);
    return {10'd0, m_seq[d], m_busy[d], m_done[d], (m_done[d] && m_err[d] == 0),
            m_mis[d], m_fev[d], 16'(m_chk[d]), 16'(m_err[d]), 16'(m_idx[d])};
  endfunction

  wire [63:0] got1 = {10'd0, s1, busy1, done1, pass1, mis1, fev1, chk1, err1, idx1};
  wire [63:0] got3 = {10'd0, s3, busy3, done3, pass3, mis3, fev3, chk3, err3, idx3};

  bit cmp_en = 1'b0;
  int mis_cnt1 = 0;

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle_dut_lat1", got1, mpack(0));
      check("cycle_dut_lat3", got3, mpack(1));
      if (mis1 === 1'b1) mis_cnt1++;
    end
  end

  // One run: start pulse, then one operand sample per cycle until both done
  task automatic do_run(input logic [1:0] op0, input int inj_idx, input int mid_idx,
                        input int abort_at, input bit bad_seq,
                        output int d1, output int d3);
    logic [1:0] cur;
    cur = op0;
    d1 = -1;
    d3 = -1;
    start = 1'b1; a = 7'($urandom); b = 7'($urandom); op = cur;
    @(negedge clk);
    start = 1'b0;
    check("run_start_busy", {busy1, chk1}, {1'b1, 16'd0});
    for (int j = 0; j < 80 && (d1 < 0 || d3 < 0); j++) begin
      a = 7'($urandom); b = 7'($urandom); inj = 1'b0; op = cur;
      if (bad_seq && j < 3) op = (j == 0) ? 2'b00 : (j == 1) ? 2'b01 : 2'b10;
      if (j == inj_idx) begin a = 7'h55; b = 7'h0F; op = 2'b00; inj = 1'b1; end
      start = (j == mid_idx);
      cur = next_op(op);
      @(negedge clk);
      if (abort_at > 0 && chk1 == 16'(abort_at)) begin
        start = 1'b0; inj = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("reset_midrun_lat1", got1, 64'd0);
        check("reset_midrun_lat3", got3, 64'd0);
        rst = 1'b0;
        return;
      end
      if (done1 && d1 < 0) d1 = j + 2;
      if (done3 && d3 < 0) d3 = j + 2;
    end
    start = 1'b0;
    inj = 1'b0;
    if (d1 < 0 || d3 < 0) check("run_timeout_done", {done1, done3}, 2'b11);
  endtask

  initial begin
    int d1, d3, mis_before;
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset_state_lat1", got1, 64'd0);
    check("reset_state_lat3", got3, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Correct unit, with a start pulse ignored mid-CHECK
    do_run(2'b00, -1, 8, 0, 0, d1, d3);
    check("A_done_delay_lat1", d1, 22);
    check("A_done_delay_lat3", d3, 24);
    check("A_lat1_chk_err_pass", {chk1, err1, pass1}, {16'd20, 16'd0, 1'b1});
    check("A_lat3_chk_err_pass", {chk3, err3, pass3}, {16'd20, 16'd0, 1'b1});

    // Restart from DONE with a single corrupted result on the 6th compare
    mis_before = mis_cnt1;
    do_run(2'b10, 5, -1, 0, 0, d1, d3);
    check("B_err_count", err1, 16'd1);
    check("B_first_err_idx", {fev1, idx1}, {1'b1, 16'd5});
    check("B_pass_low", {done1, pass1}, 2'b10);
    check("B_mismatch_pulses", mis_cnt1 - mis_before, 1);
    check("B_lat3_clean", err3, 16'd0);

    // Latency sweep: 3-stage unit seen by the LATENCY=1 checker
    use3 = 1'b1;
    do_run(2'b00, -1, -1, 0, 0, d1, d3);
    check("C_lat1_sees_errors", (err1 != 16'd0), 1'b1);
    check("C_lat3_pass", {err3, pass3}, {16'd0, 1'b1});
    use3 = 1'b0;

    // Reset at compare 10, then a fresh complete run
    do_run(2'b00, -1, -1, 10, 0, d1, d3);
    @(negedge clk);
    do_run(2'b01, -1, -1, 0, 0, d1, d3);
    check("E_done_delay_lat1", d1, 22);
    check("E_lat1_result", {chk1, err1, pass1}, {16'd20, 16'd0, 1'b1});

`ifdef BITWISE_CHECK_SEQ_EN
    do_run(2'b00, -1, -1, 0, 1, d1, d3);
    check("S_seq_err", s1, 1'b1);
    check("S_err_at_third", {err1, idx1}, {16'd1, 16'd2});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
